// File: rtl/stage_preif.sv
// Pre-IF stage: owns the fetch PC, drives the instruction SRAM request and
// hands the fetched PC to IF. Flush and branch redirects are taken here.
module stage_preif #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        allowout,
  output logic        validout,
  output logic [31:0] output_pc,
  output logic        output_adef,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata
);

  logic [31:0] pc;
  logic        valid;
  logic [31:0] nextpc;
  logic        advance;
  logic        redirect;

  assign redirect = flush || br_taken;

  // Flush outranks branch; otherwise fall through to the next word.
  always_comb begin
    nextpc = pc + 32'd4;
    if (flush)
      nextpc = flush_target;
    else if (br_taken)
      nextpc = br_target;
  end

  assign advance = !valid || redirect || allowout;

  // While stalled, re-issue the held PC so SRAM read data stays stable for IF.
  assign inst_sram_addr  = advance ? nextpc : pc;
  assign inst_sram_en    = !rst && (inst_sram_addr[1:0] == 2'b00);
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  assign validout    = valid && !redirect;
  assign output_pc   = pc;
  assign output_adef = validout && (pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC - 32'd4;
      valid <= 1'b0;
    end else if (advance) begin
      pc    <= nextpc;
      valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_preif.sv
// Self-checking bench for stage_preif: directed scenarios plus a randomized
// run compared against a fetch-stream reference model.
module tb_stage_preif;

  localparam logic [31:0] RP = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        allowout;
  logic        validout;
  logic [31:0] output_pc;
  logic        output_adef;
  logic        flush;
  logic [31:0] flush_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  int errors = 0;
  int checks = 0;

  // Reference model: the PC currently held and whether it holds anything.
  logic [31:0] m_pc;
  logic        m_valid;

  stage_preif #(.RESET_PC(RP)) dut (
    .clk(clk), .rst(rst), .allowout(allowout), .validout(validout),
    .output_pc(output_pc), .output_adef(output_adef), .flush(flush),
    .flush_target(flush_target), .br_taken(br_taken), .br_target(br_target),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_addr();
    if (flush) return flush_target;
    if (br_taken) return br_target;
    if (m_valid && !allowout) return m_pc;
    return m_pc + 32'd4;
  endfunction

  function automatic logic m_en();
    logic [31:0] a;
    a = m_addr();
    return !rst && (a[1:0] == 2'b00);
  endfunction

  function automatic logic m_vo();
    return m_valid && !flush && !br_taken;
  endfunction

  function automatic logic m_adef();
    return m_vo() && (m_pc[1:0] != 2'b00);
  endfunction

  // Drive inputs (called just after a rising edge) and move to the sampling point.
  task apply(input logic a, input logic f, input logic [31:0] ft,
             input logic b, input logic [31:0] bt);
    allowout = a; flush = f; flush_target = ft; br_taken = b; br_target = bt;
    @(negedge clk);
  endtask

  task tick();
    logic [31:0] nxt;
    @(posedge clk);
    if (!rst) begin
      nxt = m_addr();
      m_pc = nxt;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task test_reset();
    rst = 1'b1;
    m_pc = RP - 32'd4; m_valid = 1'b0;
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (validout !== 1'b0) begin errors++; $display("[TB] FAIL reset_validout: got %b expected 0", validout); end
    checks++;
    if (inst_sram_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", inst_sram_en); end
    checks++;
    if (output_adef !== 1'b0) begin errors++; $display("[TB] FAIL reset_adef: got %b expected 0", output_adef); end
    checks++;
    if (inst_sram_we !== 4'b0 || inst_sram_wdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_write: got we=%h wdata=%h expected 0/0", inst_sram_we, inst_sram_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task test_sequential();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h1c000000; exp_addr[1] = 32'h1c000004; exp_addr[2] = 32'h1c000008;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (inst_sram_addr !== exp_addr[i] || inst_sram_en !== 1'b1) begin
        errors++; $display("[TB] FAIL seq_addr%0d: got %h en=%b expected %h en=1", i, inst_sram_addr, inst_sram_en, exp_addr[i]);
      end
      checks++;
      if (validout !== (i != 0)) begin errors++; $display("[TB] FAIL seq_valid%0d: got %b expected %b", i, validout, i != 0); end
      if (i != 0) begin
        checks++;
        if (output_pc !== exp_addr[i-1]) begin errors++; $display("[TB] FAIL seq_pc%0d: got %h expected %h", i, output_pc, exp_addr[i-1]); end
      end
      tick();
    end
  endtask

  task test_stall();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checks++;
      if (inst_sram_addr !== 32'h1c000008 || validout !== 1'b1 || output_pc !== 32'h1c000008) begin
        errors++; $display("[TB] FAIL stall%0d: got addr=%h vo=%b pc=%h expected 1c000008/1/1c000008", i, inst_sram_addr, validout, output_pc);
      end
      tick();
    end
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (inst_sram_addr !== 32'h1c00000c) begin errors++; $display("[TB] FAIL stall_release: got %h expected 1c00000c", inst_sram_addr); end
    tick();
  endtask

  task test_branch_stall();
    apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h1c000100);
    checks++;
    if (validout !== 1'b0 || inst_sram_addr !== 32'h1c000100) begin
      errors++; $display("[TB] FAIL br_stall: got vo=%b addr=%h expected 0/1c000100", validout, inst_sram_addr);
    end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (validout !== 1'b1 || output_pc !== 32'h1c000100) begin
      errors++; $display("[TB] FAIL br_stall_next: got vo=%b pc=%h expected 1/1c000100", validout, output_pc);
    end
    tick();
  endtask

  task test_flush_vs_branch();
    apply(1'b1, 1'b1, 32'h1c008000, 1'b1, 32'h1c000100);
    checks++;
    if (inst_sram_addr !== 32'h1c008000 || validout !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_prio: got addr=%h vo=%b expected 1c008000/0", inst_sram_addr, validout);
    end
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (output_pc !== 32'h1c008000 || validout !== 1'b1) begin
      errors++; $display("[TB] FAIL flush_next: got pc=%h vo=%b expected 1c008000/1", output_pc, validout);
    end
    tick();
  endtask

  task test_misaligned();
    apply(1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000102);
    checks++;
    if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'h1c000102) begin
      errors++; $display("[TB] FAIL misalign_en: got en=%b addr=%h expected 0/1c000102", inst_sram_en, inst_sram_addr);
    end
    tick();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (output_adef !== 1'b1 || validout !== 1'b1 || output_pc !== 32'h1c000102) begin
      errors++; $display("[TB] FAIL misalign_adef: got adef=%b vo=%b pc=%h expected 1/1/1c000102", output_adef, validout, output_pc);
    end
    tick();
  endtask

  task test_reset_midstream();
    apply(1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000040);
    tick();
    apply(1'b1, 1'b1, 32'h1c009000, 1'b0, 32'h0);
    checks++;
    if (output_pc !== 32'h1c000040 || validout !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_pre: got pc=%h vo=%b expected 1c000040/0", output_pc, validout);
    end
    rst = 1'b1;
    m_pc = RP - 32'd4; m_valid = 1'b0;
    #1;
    checks++;
    if (validout !== 1'b0 || inst_sram_en !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset: got vo=%b en=%b expected 0/0", validout, inst_sram_en);
    end
    tick();
    rst = 1'b0;
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (inst_sram_addr !== RP || inst_sram_en !== 1'b1 || validout !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_restart: got addr=%h en=%b vo=%b expected 1c000000/1/0", inst_sram_addr, inst_sram_en, validout);
    end
    tick();
  endtask

  task test_wrap();
    apply(1'b1, 1'b0, 32'h0, 1'b1, 32'hfffffffc);
    tick();
    apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (inst_sram_addr !== 32'h00000000 || output_pc !== 32'hfffffffc || inst_sram_en !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap: got addr=%h pc=%h en=%b expected 00000000/fffffffc/1", inst_sram_addr, output_pc, inst_sram_en);
    end
    tick();
  endtask

  task test_random();
    logic [31:0] ft, bt;
    for (int i = 0; i < 300; i++) begin
      ft = {$urandom_range(0, 65535), 14'h0, 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0)};
      bt = {16'h1c00, 14'($urandom), 2'($urandom_range(0, 4) == 0 ? $urandom_range(1, 3) : 0)};
      apply(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0), ft,
            1'($urandom_range(0, 4) == 0), bt);
      checks++;
      if (inst_sram_addr !== m_addr() || inst_sram_en !== m_en()) begin
        errors++; $display("[TB] FAIL rand_req%0d: got addr=%h en=%b expected %h/%b", i, inst_sram_addr, inst_sram_en, m_addr(), m_en());
      end
      checks++;
      if (validout !== m_vo() || output_adef !== m_adef() || (m_vo() && output_pc !== m_pc)) begin
        errors++; $display("[TB] FAIL rand_out%0d: got vo=%b adef=%b pc=%h expected %b/%b/%h", i, validout, output_adef, output_pc, m_vo(), m_adef(), m_pc);
      end
      tick();
    end
  endtask

  initial begin
    allowout = 1'b1; flush = 1'b0; flush_target = 32'h0; br_taken = 1'b0; br_target = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_stall();
    test_flush_vs_branch();
    test_misaligned();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
